// File: rtl/log_capture_mem_pkg.sv
// Shared types and default sizes for the log capture buffer.
// State encoding plus default word/address widths.
package log_capture_mem_pkg;

   localparam int NB_DATA_DEF = 32;
   localparam int NB_ADDR_DEF = 15;
   localparam int NB_DEC_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } state_t;

endpackage

// File: rtl/log_capture_mem_if.sv
// Capture/readback bundle between datapath, register file and buffer.
// master: drives i_*; slave (buffer): drives o_full, o_busy, o_data.
interface log_capture_mem_if
   import log_capture_mem_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_ADDR = NB_ADDR_DEF,
   parameter int NB_DEC  = NB_DEC_DEF
);

   logic               i_valid;
   logic [NB_DATA-1:0] i_data;
   logic [NB_DEC-1:0]  i_decim;
   logic               i_run;
   logic               i_read;
   logic [NB_ADDR-1:0] i_addr;
   logic               o_full;
   logic               o_busy;
   logic [NB_DATA-1:0] o_data;

   modport master (
      output i_valid, i_data, i_decim, i_run, i_read, i_addr,
      input  o_full, o_busy, o_data
   );

   modport slave (
      input  i_valid, i_data, i_decim, i_run, i_read, i_addr,
      output o_full, o_busy, o_data
   );

endinterface

// File: rtl/log_ram_sdp.sv
// Simple dual-port buffer RAM: one write port, one registered read port.
// Ports: clock, reset (read register only), we/waddr/wdata, re/raddr/rdata.
module log_ram_sdp #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               we,
   input  logic [NB_ADDR-1:0] waddr,
   input  logic [NB_DATA-1:0] wdata,
   input  logic               re,
   input  logic [NB_ADDR-1:0] raddr,
   output logic [NB_DATA-1:0] rdata
);

   logic [NB_DATA-1:0] mem [2**NB_ADDR];

   always_ff @(posedge clock) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Array itself is never reset; only the output register is.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         rdata <= '0;
      else if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/log_capture_mem.sv
// Capture buffer: logs decimated datapath words after a run pulse,
// then serves them by address. Ports: clock, reset, bus (slave).
module log_capture_mem
   import log_capture_mem_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_ADDR = NB_ADDR_DEF,
   parameter int NB_DEC  = NB_DEC_DEF
) (
   input  logic              clock,
   input  logic              reset,
   log_capture_mem_if.slave  bus
);

   localparam logic [NB_ADDR-1:0] LAST = '1;

   state_t             state_q, state_d;
   logic [NB_ADDR-1:0] ptr_q, ptr_d;
   logic [NB_DEC-1:0]  cnt_q, cnt_d;
   logic               we;
   logic               re;
   logic [NB_DATA-1:0] rdata;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter value 0 marks the kept strobe, so the first
   // strobe after a (re)start is always written.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      we      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.i_run) begin
               state_d = FILL;
               ptr_d   = '0;
               cnt_d   = '0;
            end
         end
         FILL: begin
            if (bus.i_run) begin
               ptr_d = '0;
               cnt_d = '0;
            end else if (bus.i_valid) begin
               if (cnt_q >= bus.i_decim)
                  cnt_d = '0;
               else
                  cnt_d = cnt_q + 1'b1;
               if (cnt_q == '0) begin
                  we = 1'b1;
                  if (ptr_q == LAST)
                     state_d = FULL;
                  else
                     ptr_d = ptr_q + 1'b1;
               end
            end
         end
         FULL: begin
            if (bus.i_run) begin
               state_d = FILL;
               ptr_d   = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign re = bus.i_read && (state_q == FULL);

   log_ram_sdp #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR)
   ) u_ram (
      .clock (clock),
      .reset (reset),
      .we    (we),
      .waddr (ptr_q),
      .wdata (bus.i_data),
      .re    (re),
      .raddr (bus.i_addr),
      .rdata (rdata)
   );

   assign bus.o_full = (state_q == FULL);
   assign bus.o_busy = (state_q == FILL);
   assign bus.o_data = rdata;

endmodule

// File: tb/tb_log_capture_mem.sv
// Scoreboard bench for log_capture_mem at NB_ADDR=4 (16 words).
// Read expectations are queued at drive time and popped at output.
module tb_log_capture_mem;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [31:0] sb_q [$];

   always #5 clock = ~clock;

   log_capture_mem_if #(
      .NB_DATA (32),
      .NB_ADDR (4),
      .NB_DEC  (4)
   ) bus ();

   log_capture_mem #(
      .NB_DATA (32),
      .NB_ADDR (4),
      .NB_DEC  (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic strobe(input logic [31:0] d);
      bus.i_data  = d;
      bus.i_valid = 1'b1;
      tick();
      bus.i_valid = 1'b0;
   endtask

   task automatic run_pulse();
      bus.i_run = 1'b1;
      tick();
      bus.i_run = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp);
      bus.i_addr = a;
      sb_q.push_back(exp);
      tick();
      if (sb_q.size() == 0)
         chk("sb_empty", 32'd1, 32'd0);
      else
         chk("rd", bus.o_data, sb_q.pop_front());
   endtask

   initial begin
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      bus.i_decim = '0;
      bus.i_run   = 1'b0;
      bus.i_read  = 1'b0;
      bus.i_addr  = '0;
      repeat (2) tick();
      chk("rst_full", 32'(bus.o_full), 32'd0);
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_data", bus.o_data, 32'd0);
      reset = 1'b1;
      tick();

      // strobes with no run are ignored
      for (int k = 0; k < 20; k++) begin
         strobe(32'h55 + 32'(k));
         chk("idle_full", 32'(bus.o_full), 32'd0);
         chk("idle_busy", 32'(bus.o_busy), 32'd0);
         chk("idle_data", bus.o_data, 32'd0);
      end

      // decim 0: every strobe kept
      run_pulse();
      chk("run_busy", 32'(bus.o_busy), 32'd1);
      chk("run_full", 32'(bus.o_full), 32'd0);
      for (int k = 0; k < 16; k++) begin
         strobe(32'h100 + 32'(k));
         chk("d0_full", 32'(bus.o_full), (k == 15) ? 32'd1 : 32'd0);
      end
      chk("d0_busy", 32'(bus.o_busy), 32'd0);
      for (int k = 0; k < 4; k++)
         strobe(32'hDEAD);
      bus.i_read = 1'b1;
      for (int a = 0; a < 16; a++)
         rd(4'(a), 32'h100 + 32'(a));
      bus.i_read = 1'b0;

      // decim 2: keep strobes 0,3,6,...
      bus.i_decim = 4'd2;
      run_pulse();
      for (int i = 0; i < 48; i++) begin
         strobe(32'(i));
         if (i == 44)
            chk("d2_full44", 32'(bus.o_full), 32'd0);
         if (i == 45)
            chk("d2_full45", 32'(bus.o_full), 32'd1);
      end
      bus.i_read = 1'b1;
      for (int a = 0; a < 16; a++)
         rd(4'(a), 32'(3 * a));
      bus.i_read = 1'b0;
      bus.i_decim = 4'd0;

      // restart collides with a strobe at pointer 7
      run_pulse();
      for (int k = 0; k < 7; k++)
         strobe(32'hA00 + 32'(k));
      bus.i_run   = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_data  = 32'hBAD;
      tick();
      bus.i_run   = 1'b0;
      bus.i_valid = 1'b0;
      chk("rs_full", 32'(bus.o_full), 32'd0);
      chk("rs_busy", 32'(bus.o_busy), 32'd1);
      for (int k = 0; k < 16; k++) begin
         strobe(32'hC00 + 32'(k));
         if (k == 14)
            chk("rs_full14", 32'(bus.o_full), 32'd0);
         if (k == 15)
            chk("rs_full15", 32'(bus.o_full), 32'd1);
      end
      bus.i_read = 1'b1;
      for (int a = 0; a < 16; a++)
         rd(4'(a), 32'hC00 + 32'(a));
      rd(4'd3, 32'hC03);
      bus.i_read = 1'b0;

      // rerun after full; reads in FILL hold o_data
      run_pulse();
      chk("rr_full", 32'(bus.o_full), 32'd0);
      chk("rr_busy", 32'(bus.o_busy), 32'd1);
      bus.i_read = 1'b1;
      rd(4'd5, 32'hC03);
      bus.i_read = 1'b0;
      for (int k = 0; k < 9; k++)
         strobe(32'hE00 + 32'(k));

      // asynchronous reset mid-capture
      reset = 1'b0;
      #1;
      chk("ar_busy", 32'(bus.o_busy), 32'd0);
      chk("ar_full", 32'(bus.o_full), 32'd0);
      chk("ar_data", bus.o_data, 32'd0);
      #2;
      reset = 1'b1;
      tick();
      bus.i_read = 1'b1;
      rd(4'd2, 32'd0);
      chk("ar_full2", 32'(bus.o_full), 32'd0);
      bus.i_read = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
